instruction_encoder: RTL and testbench
======================================

Name: instruction_encoder

Overview:
Inverse of the control_logic opcode decoder. Accepts a command/addressing-mode pair plus operand and serialises the matching 6502 instruction byte stream (opcode, then operand low, then operand high) with running memory addresses. Sits between the test/boot program loader and the program RAM write port, and produces decoder-compatible images for CPU bring-up. Illegal command/mode pairs are rejected with an error pulse.

Parameters:
RESET_ADDR, 16'h0000, value loaded into the write-address counter on reset.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
cmd_valid  input  1  request valid
cmd_ready  output  1  high only in IDLE; a request is accepted when cmd_valid && cmd_ready
CMD  input  6  command code, shared control_logic command constants (LDA, STA, JMP, ...)
ADDRESS  input  4  addressing-mode code, shared constants (impl, A, IMMEDIATE, zpg, zpgX, zpgY, abs, absX, absY, ind, Xind, indY, rel)
operand  input  16  operand; [7:0] only for 2-byte forms, including the pre-computed rel offset
load_en  input  1  load write-address counter
load_addr  input  16  new counter value
byte_valid  output  1  byte_data/byte_addr valid
byte_ready  input  1  sink accepts the byte when byte_valid && byte_ready
byte_data  output  8  instruction byte
byte_addr  output  16  target address of byte_data
last  output  1  high with the final byte of an instruction
err  output  1  one-cycle pulse: illegal CMD/ADDRESS pair

Behaviour:
- Reset (async, immediate): state IDLE, cmd_ready=1, byte_valid=0, byte_data=0, last=0, err=0, addr counter=RESET_ADDR, byte_addr=RESET_ADDR.
- Opcode table: standard documented NMOS 6502 map (151 opcodes), combinational on registered CMD/ADDRESS. ASLA/ROLA/LSRA/RORA accept impl or A and give 0A/2A/4A/6A. JMP abs=4C, JMP ind=6C. Every pair not in the map is illegal.
- Length: impl/A=1 byte. IMMEDIATE, zpg, zpgX, zpgY, Xind, indY, rel=2. abs, absX, absY, ind=3.
- States: IDLE, OP, LO, HI.
- IDLE: on accept, register CMD/ADDRESS/operand. If legal, go to OP next cycle. If illegal, pulse err in the next cycle, stay IDLE, emit nothing, leave counter unchanged.
- OP/LO/HI: byte_valid=1. Data is opcode, operand[7:0], or operand[15:8] respectively. byte_addr = counter. last=1 on the final byte for the length.
- On byte handshake: counter+1, 16-bit wrap FFFF->0000. Advance to the next state, or to IDLE after the last byte. IDLE is reached in the cycle after the last handshake.
- Backpressure: while byte_valid && !byte_ready, byte_data, byte_addr and last hold stable. byte_valid never drops without a handshake.
- Minimum latency: accept in cycle 0, first byte valid in cycle 1. With byte_ready tied high, an n-byte instruction occupies n+1 cycles, and the next accept happens the cycle after the last byte.
- load_en is honoured only in IDLE; elsewhere it is ignored. load_en together with an accept in the same cycle: the load takes effect first, so the instruction's first byte goes to load_addr.
- cmd_valid outside IDLE is ignored; no queueing.
- rst mid-instruction: the stream is abandoned, byte_valid=0 immediately, counter=RESET_ADDR.

Test Plan:
- Reset, then load_addr=0x0200. Send LDA/IMMEDIATE, operand=0x0042, byte_ready=1 -> bytes A9@0200, 42@0201 (last=1). cmd_ready returns high the following cycle.
- STA/abs, operand=0x1234, counter=0x0300 -> 8D@0300, 34@0301, 12@0302 (last on 12). JMP/ind 0x1234 -> 6C,34,12. JMP/abs -> 4C.
- NOP/impl then ASLA/A -> EA (last=1), then 0A (last=1). Counter advances by 1 each.
- Backpressure: hold byte_ready=0 for 5 cycles during LDA/absX 0xBEEF -> BD held stable for 5 cycles; the sequence continues BD, EF, BE with no byte lost or duplicated.
- Illegal STA/IMMEDIATE -> err=1 for exactly one cycle, byte_valid stays 0, counter unchanged. Illegal LDX/zpgX -> same.
- Counter at 0xFFFF with LDA/abs 0x0400 -> AD@FFFF, 00@0000, 04@0001. Then assert rst mid-stream on a following instruction -> byte_valid=0 immediately, counter=RESET_ADDR.

Source files
------------

// File: rtl/instruction_encoder.sv
// instruction_encoder: turns a command/addressing-mode pair plus operand into
// the matching NMOS 6502 byte stream (opcode, operand low, operand high),
// each byte tagged with a running write address for the program RAM.
module instruction_encoder #(
  parameter logic [15:0] RESET_ADDR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  CMD,
  input  logic [3:0]  ADDRESS,
  input  logic [15:0] operand,
  input  logic        load_en,
  input  logic [15:0] load_addr,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic [7:0]  byte_data,
  output logic [15:0] byte_addr,
  output logic        last,
  output logic        err
);

  // Command codes (shared with the control_logic decoder)
  localparam logic [5:0] C_ADC = 6'd0,  C_AND = 6'd1,  C_ASL = 6'd2,  C_BCC = 6'd3;
  localparam logic [5:0] C_BCS = 6'd4,  C_BEQ = 6'd5,  C_BIT = 6'd6,  C_BMI = 6'd7;
  localparam logic [5:0] C_BNE = 6'd8,  C_BPL = 6'd9,  C_BRK = 6'd10, C_BVC = 6'd11;
  localparam logic [5:0] C_BVS = 6'd12, C_CLC = 6'd13, C_CLD = 6'd14, C_CLI = 6'd15;
  localparam logic [5:0] C_CLV = 6'd16, C_CMP = 6'd17, C_CPX = 6'd18, C_CPY = 6'd19;
  localparam logic [5:0] C_DEC = 6'd20, C_DEX = 6'd21, C_DEY = 6'd22, C_EOR = 6'd23;
  localparam logic [5:0] C_INC = 6'd24, C_INX = 6'd25, C_INY = 6'd26, C_JMP = 6'd27;
  localparam logic [5:0] C_JSR = 6'd28, C_LDA = 6'd29, C_LDX = 6'd30, C_LDY = 6'd31;
  localparam logic [5:0] C_LSR = 6'd32, C_NOP = 6'd33, C_ORA = 6'd34, C_PHA = 6'd35;
  localparam logic [5:0] C_PHP = 6'd36, C_PLA = 6'd37, C_PLP = 6'd38, C_ROL = 6'd39;
  localparam logic [5:0] C_ROR = 6'd40, C_RTI = 6'd41, C_RTS = 6'd42, C_SBC = 6'd43;
  localparam logic [5:0] C_SEC = 6'd44, C_SED = 6'd45, C_SEI = 6'd46, C_STA = 6'd47;
  localparam logic [5:0] C_STX = 6'd48, C_STY = 6'd49, C_TAX = 6'd50, C_TAY = 6'd51;
  localparam logic [5:0] C_TSX = 6'd52, C_TXA = 6'd53, C_TXS = 6'd54, C_TYA = 6'd55;
  localparam logic [5:0] C_ASLA = 6'd56, C_ROLA = 6'd57, C_LSRA = 6'd58, C_RORA = 6'd59;

  // Addressing-mode codes
  localparam logic [3:0] M_IMPL = 4'd0, M_ACC  = 4'd1, M_IMM  = 4'd2,  M_ZPG  = 4'd3;
  localparam logic [3:0] M_ZPGX = 4'd4, M_ZPGY = 4'd5, M_ABS  = 4'd6,  M_ABSX = 4'd7;
  localparam logic [3:0] M_ABSY = 4'd8, M_IND  = 4'd9, M_XIND = 4'd10, M_INDY = 4'd11;
  localparam logic [3:0] M_REL  = 4'd12;

  typedef enum logic [1:0] {IDLE, OP, LO, HI} state_t;

  // Arithmetic/load/store column pattern: opcode = group base + mode offset
  function automatic logic [8:0] grp_alu(input logic [7:0] base, input logic [3:0] m,
                                         input logic imm_ok);
    logic [8:0] r;
    r = '0;
    case (m)
      M_XIND: r = {1'b1, base + 8'h01};
      M_ZPG:  r = {1'b1, base + 8'h05};
      M_IMM:  r = {imm_ok, base + 8'h09};
      M_ABS:  r = {1'b1, base + 8'h0D};
      M_INDY: r = {1'b1, base + 8'h11};
      M_ZPGX: r = {1'b1, base + 8'h15};
      M_ABSY: r = {1'b1, base + 8'h19};
      M_ABSX: r = {1'b1, base + 8'h1D};
      default: r = '0;
    endcase
    return r;
  endfunction

  // Read-modify-write column pattern (shifts/rotates, INC, DEC)
  function automatic logic [8:0] grp_rmw(input logic [7:0] base, input logic [3:0] m,
                                         input logic acc_ok);
    logic [8:0] r;
    r = '0;
    case (m)
      M_ZPG:  r = {1'b1, base + 8'h06};
      M_ACC:  r = {acc_ok, base + 8'h0A};
      M_ABS:  r = {1'b1, base + 8'h0E};
      M_ZPGX: r = {1'b1, base + 8'h16};
      M_ABSX: r = {1'b1, base + 8'h1E};
      default: r = '0;
    endcase
    return r;
  endfunction

  // Returns {legal, opcode} for a command/mode pair
  function automatic logic [8:0] encode(input logic [5:0] c, input logic [3:0] m);
    logic [8:0] r;
    logic impl, rel;
    impl = (m == M_IMPL);
    rel  = (m == M_REL);
    r = '0;
    case (c)
      C_ORA: r = grp_alu(8'h00, m, 1'b1);
      C_AND: r = grp_alu(8'h20, m, 1'b1);
      C_EOR: r = grp_alu(8'h40, m, 1'b1);
      C_ADC: r = grp_alu(8'h60, m, 1'b1);
      C_STA: r = grp_alu(8'h80, m, 1'b0);
      C_LDA: r = grp_alu(8'hA0, m, 1'b1);
      C_CMP: r = grp_alu(8'hC0, m, 1'b1);
      C_SBC: r = grp_alu(8'hE0, m, 1'b1);
      C_ASL: r = grp_rmw(8'h00, m, 1'b1);
      C_ROL: r = grp_rmw(8'h20, m, 1'b1);
      C_LSR: r = grp_rmw(8'h40, m, 1'b1);
      C_ROR: r = grp_rmw(8'h60, m, 1'b1);
      C_DEC: r = grp_rmw(8'hC0, m, 1'b0);
      C_INC: r = grp_rmw(8'hE0, m, 1'b0);
      C_ASLA: r = {impl || m == M_ACC, 8'h0A};
      C_ROLA: r = {impl || m == M_ACC, 8'h2A};
      C_LSRA: r = {impl || m == M_ACC, 8'h4A};
      C_RORA: r = {impl || m == M_ACC, 8'h6A};
      C_BPL: r = {rel, 8'h10};
      C_BMI: r = {rel, 8'h30};
      C_BVC: r = {rel, 8'h50};
      C_BVS: r = {rel, 8'h70};
      C_BCC: r = {rel, 8'h90};
      C_BCS: r = {rel, 8'hB0};
      C_BNE: r = {rel, 8'hD0};
      C_BEQ: r = {rel, 8'hF0};
      C_BIT: r = (m == M_ZPG) ? 9'h124 : (m == M_ABS) ? 9'h12C : 9'h000;
      C_JMP: r = (m == M_ABS) ? 9'h14C : (m == M_IND) ? 9'h16C : 9'h000;
      C_JSR: r = {m == M_ABS, 8'h20};
      C_CPX: r = (m == M_IMM) ? 9'h1E0 : (m == M_ZPG) ? 9'h1E4 : (m == M_ABS) ? 9'h1EC : 9'h000;
      C_CPY: r = (m == M_IMM) ? 9'h1C0 : (m == M_ZPG) ? 9'h1C4 : (m == M_ABS) ? 9'h1CC : 9'h000;
      C_LDX: r = (m == M_IMM) ? 9'h1A2 : (m == M_ZPG) ? 9'h1A6 : (m == M_ZPGY) ? 9'h1B6 :
                 (m == M_ABS) ? 9'h1AE : (m == M_ABSY) ? 9'h1BE : 9'h000;
      C_LDY: r = (m == M_IMM) ? 9'h1A0 : (m == M_ZPG) ? 9'h1A4 : (m == M_ZPGX) ? 9'h1B4 :
                 (m == M_ABS) ? 9'h1AC : (m == M_ABSX) ? 9'h1BC : 9'h000;
      C_STX: r = (m == M_ZPG) ? 9'h186 : (m == M_ZPGY) ? 9'h196 : (m == M_ABS) ? 9'h18E : 9'h000;
      C_STY: r = (m == M_ZPG) ? 9'h184 : (m == M_ZPGX) ? 9'h194 : (m == M_ABS) ? 9'h18C : 9'h000;
      C_BRK: r = {impl, 8'h00};
      C_PHP: r = {impl, 8'h08};
      C_CLC: r = {impl, 8'h18};
      C_PLP: r = {impl, 8'h28};
      C_SEC: r = {impl, 8'h38};
      C_RTI: r = {impl, 8'h40};
      C_PHA: r = {impl, 8'h48};
      C_CLI: r = {impl, 8'h58};
      C_RTS: r = {impl, 8'h60};
      C_PLA: r = {impl, 8'h68};
      C_SEI: r = {impl, 8'h78};
      C_DEY: r = {impl, 8'h88};
      C_TXA: r = {impl, 8'h8A};
      C_TYA: r = {impl, 8'h98};
      C_TXS: r = {impl, 8'h9A};
      C_TAY: r = {impl, 8'hA8};
      C_TAX: r = {impl, 8'hAA};
      C_CLV: r = {impl, 8'hB8};
      C_TSX: r = {impl, 8'hBA};
      C_INY: r = {impl, 8'hC8};
      C_DEX: r = {impl, 8'hCA};
      C_CLD: r = {impl, 8'hD8};
      C_INX: r = {impl, 8'hE8};
      C_NOP: r = {impl, 8'hEA};
      C_SED: r = {impl, 8'hF8};
      default: r = '0;
    endcase
    return r;
  endfunction

  state_t      state, next_state;
  logic [5:0]  cmd_q;
  logic [3:0]  mode_q;
  logic [15:0] operand_q;
  logic [15:0] counter;
  logic [8:0]  enc_in, enc_q;
  logic [1:0]  len_q;
  logic        accept, handshake;

  assign enc_in    = encode(CMD, ADDRESS);
  assign enc_q     = encode(cmd_q, mode_q);
  assign accept    = cmd_valid && cmd_ready;
  assign handshake = byte_valid && byte_ready;
  assign byte_addr = counter;

  // Instruction length follows from the registered addressing mode
  always_comb begin
    len_q = 2'd2;
    case (mode_q)
      M_IMPL, M_ACC:                len_q = 2'd1;
      M_ABS, M_ABSX, M_ABSY, M_IND: len_q = 2'd3;
      default:                      len_q = 2'd2;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state and byte-stream outputs
  always_comb begin
    next_state = state;
    cmd_ready  = 1'b0;
    byte_valid = 1'b0;
    byte_data  = '0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid && enc_in[8]) next_state = OP;
      end
      OP: begin
        byte_valid = 1'b1;
        byte_data  = enc_q[7:0];
        last       = (len_q == 2'd1);
        if (byte_ready) next_state = last ? IDLE : LO;
      end
      LO: begin
        byte_valid = 1'b1;
        byte_data  = operand_q[7:0];
        last       = (len_q == 2'd2);
        if (byte_ready) next_state = last ? IDLE : HI;
      end
      HI: begin
        byte_valid = 1'b1;
        byte_data  = operand_q[15:8];
        last       = 1'b1;
        if (byte_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Capture the request on accept; flag illegal pairs one cycle later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_q     <= '0;
      mode_q    <= '0;
      operand_q <= '0;
      err       <= 1'b0;
    end else begin
      err <= accept && !enc_in[8];
      if (accept) begin
        cmd_q     <= CMD;
        mode_q    <= ADDRESS;
        operand_q <= operand;
      end
    end
  end

  // Write-address counter: load only while idle, step on each byte handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          counter <= RESET_ADDR;
    else if (state == IDLE && load_en) counter <= load_addr;
    else if (handshake)               counter <= counter + 16'd1;
  end

endmodule

// File: tb/tb_instruction_encoder.sv
// Self-checking bench for instruction_encoder: expected bytes are queued when
// a request is issued and compared by a monitor as the DUT hands bytes over.
module tb_instruction_encoder;

  localparam logic [15:0] RST_ADDR = 16'h0100;

  localparam logic [5:0] C_BEQ = 6'd5,  C_BIT = 6'd6,  C_CPY = 6'd19, C_INC = 6'd24;
  localparam logic [5:0] C_JMP = 6'd27, C_JSR = 6'd28, C_LDA = 6'd29, C_LDX = 6'd30;
  localparam logic [5:0] C_NOP = 6'd33, C_ORA = 6'd34, C_STA = 6'd47, C_STY = 6'd49;
  localparam logic [5:0] C_TXS = 6'd54, C_ASLA = 6'd56, C_RORA = 6'd59;
  localparam logic [3:0] M_IMPL = 4'd0, M_ACC  = 4'd1, M_IMM  = 4'd2,  M_ZPG  = 4'd3;
  localparam logic [3:0] M_ZPGX = 4'd4, M_ZPGY = 4'd5, M_ABS  = 4'd6,  M_ABSX = 4'd7;
  localparam logic [3:0] M_IND  = 4'd9, M_XIND = 4'd10, M_REL = 4'd12;

  logic        clk, rst, cmd_valid, cmd_ready, load_en, byte_valid, byte_ready, last, err;
  logic [5:0]  CMD;
  logic [3:0]  ADDRESS;
  logic [15:0] operand, load_addr, byte_addr;
  logic [7:0]  byte_data;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  logic [24:0] sb[$];
  logic [24:0] exp_e;
  logic [15:0] exp_addr;
  logic        err_allowed = 1'b0;

  instruction_encoder #(.RESET_ADDR(RST_ADDR)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .CMD(CMD), .ADDRESS(ADDRESS), .operand(operand),
    .load_en(load_en), .load_addr(load_addr),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_data(byte_data),
    .byte_addr(byte_addr), .last(last), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) cyc++;

  // Scoreboard monitor: every handshaken byte must match the queue head
  always @(negedge clk) begin
    if (!rst && byte_valid && byte_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL stream_extra got %02h@%04h last=%0b, queue empty", byte_data, byte_addr, last);
      end else begin
        exp_e = sb.pop_front();
        if ({last, byte_addr, byte_data} !== exp_e) begin
          errors++;
          $display("FAIL stream_byte got %02h@%04h last=%0b want %02h@%04h last=%0b",
                   byte_data, byte_addr, last, exp_e[7:0], exp_e[23:8], exp_e[24]);
        end
      end
    end
    if (!rst && err && !err_allowed) begin
      checks++;
      errors++;
      $display("FAIL err_spurious got err=1 want 0");
    end
  end

  // Wait for IDLE, present one request, queue its expected bytes
  task automatic issue(input logic [5:0] c, input logic [3:0] m, input logic [15:0] op,
                       input int n, input logic [7:0] opc);
    int t = 0;
    logic [7:0] d;
    @(posedge clk); #2;
    while (!cmd_ready && t < 100) begin @(posedge clk); #2; t++; end
    if (!cmd_ready) begin
      checks++; errors++;
      $display("FAIL ready_timeout got cmd_ready=0 want 1");
    end
    CMD = c; ADDRESS = m; operand = op; cmd_valid = 1'b1;
    acc_cyc = cyc;
    for (int i = 0; i < n; i++) begin
      d = (i == 0) ? opc : (i == 1) ? op[7:0] : op[15:8];
      sb.push_back({(i == n - 1), exp_addr, d});
      exp_addr = exp_addr + 16'd1;
    end
    @(posedge clk); #2;
    cmd_valid = 1'b0; load_en = 1'b0;
  endtask

  task automatic drain(input string name);
    int t = 0;
    while ((sb.size() != 0 || !cmd_ready) && t < 200) begin @(posedge clk); #2; t++; end
    checks++;
    if (sb.size() != 0 || !cmd_ready) begin
      errors++;
      $display("FAIL %s_drain got %0d bytes pending ready=%0b want 0 pending ready=1",
               name, sb.size(), cmd_ready);
    end
  endtask

  task automatic load(input logic [15:0] a);
    @(posedge clk); #2;
    load_en = 1'b1; load_addr = a;
    @(posedge clk); #2;
    load_en = 1'b0;
    exp_addr = a;
    checks++;
    if (byte_addr !== a) begin
      errors++;
      $display("FAIL load_addr got %04h want %04h", byte_addr, a);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; cmd_valid = 1'b0; CMD = '0; ADDRESS = '0; operand = '0;
    load_en = 1'b0; load_addr = '0; byte_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if ({cmd_ready, byte_valid, byte_data, last, err, byte_addr} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, RST_ADDR}) begin
      errors++;
      $display("FAIL reset_state got rdy=%0b v=%0b d=%02h l=%0b e=%0b a=%04h want 1 0 00 0 0 %04h",
               cmd_ready, byte_valid, byte_data, last, err, byte_addr, RST_ADDR);
    end
    rst = 1'b0;
    exp_addr = RST_ADDR;
  endtask

  task automatic test_lda_imm;
    load(16'h0200);
    issue(C_LDA, M_IMM, 16'h0042, 2, 8'hA9);
    checks++;
    if (byte_valid !== 1'b1 || byte_data !== 8'hA9 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL lda_latency got v=%0b d=%02h rdy=%0b want 1 A9 0", byte_valid, byte_data, cmd_ready);
    end
    @(posedge clk); #2;
    checks++;
    if (cmd_ready !== 1'b0 || last !== 1'b1) begin
      errors++;
      $display("FAIL lda_second got rdy=%0b last=%0b want 0 1", cmd_ready, last);
    end
    @(posedge clk); #2;
    checks++;
    if (cmd_ready !== 1'b1 || byte_valid !== 1'b0) begin
      errors++;
      $display("FAIL lda_idle got rdy=%0b v=%0b want 1 0", cmd_ready, byte_valid);
    end
  endtask

  task automatic test_abs_ind;
    load(16'h0300);
    issue(C_STA, M_ABS, 16'h1234, 3, 8'h8D);
    issue(C_JMP, M_IND, 16'h1234, 3, 8'h6C);
    issue(C_JMP, M_ABS, 16'h5678, 3, 8'h4C);
    drain("abs_ind");
  endtask

  task automatic test_implied;
    load_addr = 16'h0500; load_en = 1'b1;
    exp_addr = 16'h0500;
    issue(C_NOP, M_IMPL, 16'hFFFF, 1, 8'hEA);
    issue(C_ASLA, M_ACC, 16'h0000, 1, 8'h0A);
    issue(C_ASLA, M_IMPL, 16'h0000, 1, 8'h0A);
    drain("implied");
    checks++;
    if (byte_addr !== 16'h0503) begin
      errors++;
      $display("FAIL implied_counter got %04h want 0503", byte_addr);
    end
  endtask

  task automatic test_backpressure;
    logic [15:0] start;
    byte_ready = 1'b0;
    start = exp_addr;
    issue(C_LDA, M_ABSX, 16'hBEEF, 3, 8'hBD);
    load_en = 1'b1; load_addr = 16'hAAAA;
    cmd_valid = 1'b1; CMD = C_NOP; ADDRESS = M_IMPL;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({byte_valid, byte_data, byte_addr, last} !== {1'b1, 8'hBD, start, 1'b0}) begin
        errors++;
        $display("FAIL stall_hold got v=%0b %02h@%04h l=%0b want 1 BD@%04h l=0",
                 byte_valid, byte_data, byte_addr, last, start);
      end
      @(posedge clk); #2;
    end
    load_en = 1'b0; cmd_valid = 1'b0;
    byte_ready = 1'b1;
    drain("backpressure");
  endtask

  task automatic test_illegal;
    logic [5:0] cs[2];
    logic [3:0] ms[2];
    logic [15:0] saved;
    cs[0] = C_STA; ms[0] = M_IMM;
    cs[1] = C_LDX; ms[1] = M_ZPGX;
    for (int k = 0; k < 2; k++) begin
      saved = exp_addr;
      err_allowed = 1'b1;
      CMD = cs[k]; ADDRESS = ms[k]; operand = 16'h00FF; cmd_valid = 1'b1;
      @(posedge clk); #2;
      cmd_valid = 1'b0;
      checks++;
      if (err !== 1'b1 || byte_valid !== 1'b0) begin
        errors++;
        $display("FAIL illegal%0d_pulse got err=%0b v=%0b want 1 0", k, err, byte_valid);
      end
      @(posedge clk); #2;
      checks++;
      if ({err, byte_valid, cmd_ready, byte_addr} !== {1'b0, 1'b0, 1'b1, saved}) begin
        errors++;
        $display("FAIL illegal%0d_after got err=%0b v=%0b rdy=%0b a=%04h want 0 0 1 %04h",
                 k, err, byte_valid, cmd_ready, byte_addr, saved);
      end
      err_allowed = 1'b0;
    end
  endtask

  task automatic test_back_to_back;
    logic [5:0]  cs[10];
    logic [3:0]  ms[10];
    logic [7:0]  ops[10];
    int          ns[10];
    int          prev;
    cs = '{C_ORA, C_INC, C_BEQ, C_TXS, C_LDX, C_STY, C_JSR, C_RORA, C_CPY, C_BIT};
    ms = '{M_XIND, M_ABSX, M_REL, M_IMPL, M_ZPGY, M_ZPGX, M_ABS, M_ACC, M_IMM, M_ABS};
    ops = '{8'h01, 8'hFE, 8'hF0, 8'h9A, 8'hB6, 8'h94, 8'h20, 8'h6A, 8'hC0, 8'h2C};
    ns = '{2, 3, 2, 1, 2, 2, 3, 1, 2, 3};
    prev = 0;
    for (int i = 0; i < 10; i++) begin
      issue(cs[i], ms[i], 16'h1000 + 16'(i * 16'h0111), ns[i], ops[i]);
      if (i > 0) begin
        checks++;
        if (acc_cyc - prev !== ns[i - 1] + 1) begin
          errors++;
          $display("FAIL b2b_gap%0d got %0d cycles want %0d", i, acc_cyc - prev, ns[i - 1] + 1);
        end
      end
      prev = acc_cyc;
    end
    drain("back_to_back");
  endtask

  task automatic test_wrap_and_reset;
    load(16'hFFFF);
    issue(C_LDA, M_ABS, 16'h0400, 3, 8'hAD);
    drain("wrap");
    byte_ready = 1'b0;
    issue(C_STA, M_ABS, 16'h1234, 3, 8'h8D);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    sb.delete();
    checks++;
    if ({byte_valid, byte_addr, cmd_ready} !== {1'b0, RST_ADDR, 1'b1}) begin
      errors++;
      $display("FAIL midreset got v=%0b a=%04h rdy=%0b want 0 %04h 1", byte_valid, byte_addr, cmd_ready, RST_ADDR);
    end
    @(posedge clk); #2;
    rst = 1'b0;
    byte_ready = 1'b1;
    exp_addr = RST_ADDR;
    issue(C_NOP, M_IMPL, 16'h0000, 1, 8'hEA);
    drain("post_reset");
  endtask

  initial begin
    test_reset();
    test_lda_imm();
    test_abs_ind();
    test_implied();
    test_backpressure();
    test_illegal();
    test_back_to_back();
    test_wrap_and_reset();
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
